// File: rtl/calc_pkg.sv
// Shared definitions for the calc scheduler: operation encoding, FSM states
// and the iteration-count helper.
package calc_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // MUL and DIV run one step per operand bit; ADD and SUB take a single step.
  function automatic logic is_iter(input op_t op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/calc_arb.sv
// Two-requester arbiter for calc_sched. Round-robin when CALC_SCHED_RR_EN is
// defined, otherwise fixed priority with requester 0 winning.
module calc_arb
  import calc_pkg::*;
(
  input  logic       clock,
  input  logic       reset,   // active-low, asynchronous
  input  logic [1:0] req,
  input  logic       update,
  input  logic       served,
  output logic [1:0] grant
);

`ifdef CALC_SCHED_RR_EN
  logic last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last <= 1'b1;
    end else if (update) begin
      last <= served;
    end
  end

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end
`else
  logic unused_arb;
  assign unused_arb = ^{clock, reset, update, served};

  always_comb begin
    grant = 2'b00;
    if (req[0]) begin
      grant = 2'b01;
    end else if (req[1]) begin
      grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/calc_sched.sv
// Control sequencer for a shared iterative ALU serving two requesters.
// Optional round-robin arbitration is enabled with CALC_SCHED_RR_EN.
module calc_sched
  import calc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic [3:0] fct_i,
  output logic [1:0] gnt_o,
  output logic       sel_o,
  output logic       a_we_o,
  output logic       b_we_o,
  output logic       fct_we_o,
  output logic       step_o,
  output logic       res_we_o,
  output logic       rem_we_o,
  output logic [1:0] done_o,
  output logic       busy_o,
  output state_t     dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t        state_q, state_d;
  logic          sel_q;
  op_t           op_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    arb_grant;
  op_t           load_op;

  calc_arb u_arb (
    .clock  (clock_i),
    .reset  (reset_i),
    .req    (req_i),
    .update (state_q == ST_LOAD),
    .served (sel_q),
    .grant  (arb_grant)
  );

  assign load_op = op_t'(fct_i[{sel_q, 1'b0} +: 2]);

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      op_q    <= OP_ADD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && (|req_i)) begin
        sel_q <= arb_grant[1];
      end
      if (state_q == ST_LOAD) begin
        op_q  <= load_op;
        cnt_q <= is_iter(load_op) ? CW'(WIDTH) : CW'(1);
      end else if (state_q == ST_EXEC && cnt_q > CW'(1)) begin
        // Held at 1 on the final step so it never wraps.
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_o    = 2'b00;
    a_we_o   = 1'b0;
    b_we_o   = 1'b0;
    fct_we_o = 1'b0;
    step_o   = 1'b0;
    res_we_o = 1'b0;
    rem_we_o = 1'b0;
    done_o   = 2'b00;
    busy_o   = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (|req_i) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        a_we_o   = 1'b1;
        b_we_o   = 1'b1;
        fct_we_o = 1'b1;
        gnt_o    = sel_q ? 2'b10 : 2'b01;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        step_o = 1'b1;
        if (cnt_q == CW'(1)) state_d = ST_STORE;
      end
      ST_STORE: begin
        res_we_o = 1'b1;
        rem_we_o = (op_q == OP_DIV);
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        done_o  = sel_q ? 2'b10 : 2'b01;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sel_o     = sel_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_calc_sched.sv
// Self-checking bench for calc_sched: per-cycle output checks against the
// expected phase sequence plus a done-vector scoreboard.
module tb_calc_sched;
  import calc_pkg::*;

  localparam int WIDTH = 8;

  logic       clock_i = 1'b0;
  logic       reset_i = 1'b0;
  logic [1:0] req_i   = 2'b00;
  logic [3:0] fct_i   = 4'b0000;
  logic [1:0] gnt_o;
  logic       sel_o;
  logic       a_we_o, b_we_o, fct_we_o, step_o, res_we_o, rem_we_o;
  logic [1:0] done_o;
  logic       busy_o;
  state_t     dbg_state;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  calc_sched #(.WIDTH(WIDTH)) dut (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .req_i     (req_i),
    .fct_i     (fct_i),
    .gnt_o     (gnt_o),
    .sel_o     (sel_o),
    .a_we_o    (a_we_o),
    .b_we_o    (b_we_o),
    .fct_we_o  (fct_we_o),
    .step_o    (step_o),
    .res_we_o  (res_we_o),
    .rem_we_o  (rem_we_o),
    .done_o    (done_o),
    .busy_o    (busy_o),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [10:0] outs();
    return {gnt_o, a_we_o, b_we_o, fct_we_o, step_o, res_we_o, rem_we_o, done_o, busy_o};
  endfunction

  // phase: 0 idle, 1 load, 2 exec, 3 store, 4 done
  function automatic logic [10:0] exp_outs(input int phase, input logic [1:0] g, input logic [1:0] op);
    logic ld;
    ld = (phase == 1);
    return {(ld ? g : 2'b00), ld, ld, ld, (phase == 2), (phase == 3),
            (phase == 3 && op == 2'b11), (phase == 4 ? g : 2'b00), (phase != 0)};
  endfunction

  // mode: 0 normal, 1 drop req after LOAD, 2 toggle req/fct during EXEC, 3 keep req held
  task automatic run_op(input logic [1:0] req, input logic [3:0] fct, input logic [1:0] exp_gnt,
                        input int mode, input string tag);
    logic       w;
    logic [3:0] f;
    logic [1:0] op;
    int         n;
    int         phase;
    w  = exp_gnt[1];
    f  = fct;
    op = f[{w, 1'b0} +: 2];
    n  = op[1] ? WIDTH : 1;
    exp_q.push_back(exp_gnt);
    req_i = req;
    fct_i = fct;
    for (int c = 1; c <= n + 4; c++) begin
      @(negedge clock_i);
      phase = (c == 1) ? 1 : (c <= n + 1) ? 2 : (c == n + 2) ? 3 : (c == n + 3) ? 4 : 0;
      check({tag, "_outs"}, 32'(outs()), 32'(exp_outs(phase, exp_gnt, op)));
      if (phase != 0) check({tag, "_sel"}, 32'(sel_o), 32'(w));
      if (phase == 4) begin
        if (exp_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
        else check({tag, "_done"}, 32'(done_o), 32'(exp_q.pop_front()));
      end
      if (mode == 1 && c == 1) req_i = 2'b00;
      if (mode == 2 && phase == 2) begin
        req_i = 2'($urandom_range(0, 3));
        fct_i = 4'($urandom_range(0, 15));
      end
      if (mode != 3 && c == n + 3) req_i = 2'b00;
    end
  endtask

  initial begin
    logic [1:0] g2;
    logic [3:0] rf;
    logic [1:0] rr;

    // reset state
    repeat (2) @(negedge clock_i);
    check("reset_outs", 32'(outs()), 32'd0);
    check("reset_sel", 32'(sel_o), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    reset_i = 1'b1;
    @(negedge clock_i);

    run_op(2'b01, 4'b0000, 2'b01, 0, "add0");
    run_op(2'b10, 4'b1000, 2'b10, 0, "mul1");
    run_op(2'b01, 4'b0011, 2'b01, 0, "div0");
    run_op(2'b01, 4'b0010, 2'b01, 2, "tog0");
    run_op(2'b10, 4'b0100, 2'b10, 1, "drop1");

    // simultaneous requests held over three operations
`ifdef CALC_SCHED_RR_EN
    g2 = 2'b10;
`else
    g2 = 2'b01;
`endif
    run_op(2'b11, 4'b1101, 2'b01, 3, "pair_a");
    run_op(2'b11, 4'b1101, g2, 3, "pair_b");
    run_op(2'b11, 4'b1101, 2'b01, 0, "pair_c");

    // reset in the middle of a MUL
    req_i = 2'b01;
    fct_i = 4'b0010;
    repeat (4) @(negedge clock_i);
    check("abort_pre_busy", 32'(busy_o), 32'd1);
    reset_i = 1'b0;
    req_i   = 2'b00;
    #1;
    check("abort_outs", 32'(outs()), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clock_i);
    reset_i = 1'b1;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(negedge clock_i);
      check("abort_quiet", 32'(outs()), 32'd0);
    end

    // random single-requester operations after the abort
    for (int i = 0; i < 6; i++) begin
      rr = $urandom_range(0, 1) ? 2'b10 : 2'b01;
      rf = 4'($urandom_range(0, 15));
      run_op(rr, rf, rr, $urandom_range(0, 2), "rand");
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_sched.md
CALC_SCHED -- requirements
Module: calc_sched

Interface
REQ-001 Parameter WIDTH, default 8, operand width; sets the iteration count for MUL/DIV.
REQ-002 clock_i  input  1  clock; all state updates on rising edge.
REQ-003 reset_i  input  1  reset, asynchronous, active-low.
REQ-004 req_i  input  2  per-requester operation request, level; held until granted.
REQ-005 fct_i  input  4  op codes; bits[1:0] for requester 0, bits[3:2] for requester 1.
REQ-006 gnt_o  output  2  one-hot grant, high for exactly the LOAD cycle.
REQ-007 sel_o  output  1  operand mux select (index of granted requester), stable LOAD through DONE.
REQ-008 a_we_o, b_we_o, fct_we_o  output  1 each  datapath operand/op register write enables.
REQ-009 step_o  output  1  datapath iteration enable.
REQ-010 res_we_o, rem_we_o  output  1 each  result/remainder register write enables.
REQ-011 done_o  output  2  one-hot completion pulse to the granted requester.
REQ-012 busy_o  output  1  high in every state except IDLE.

Function
REQ-013 States SHALL be IDLE, LOAD, EXEC, STORE, DONE; outputs are a Moore decode of state, sel and op.
REQ-014 IDLE: any req_i bit high -> latch grantee into sel, go LOAD; else stay.
REQ-015 LOAD, 1 cycle: a_we_o=b_we_o=fct_we_o=1, gnt_o[sel]=1; iteration counter loaded with 1 for ADD/SUB, WIDTH for MUL/DIV, from fct_i of the grantee; go EXEC.
REQ-016 EXEC: step_o=1 every cycle; counter decrements; counter==1 -> STORE.
REQ-017 STORE, 1 cycle: res_we_o=1; rem_we_o=1 only when the latched op is DIV; go DONE.
REQ-018 DONE, 1 cycle: done_o[sel]=1; go IDLE.
REQ-019 Latency: request sampled in IDLE at cycle T -> gnt at T+1, done at T+3+N (N = iteration count).
REQ-020 Requests arriving while busy_o=1 SHALL be ignored until IDLE; a request still high in IDLE is re-arbitrated normally.
REQ-021 A requester dropping req_i after LOAD SHALL NOT affect the operation in progress.
REQ-022 Counter width SHALL be clog2(WIDTH+1); it never wraps below 1 in EXEC.
REQ-023 All enables not listed for a state SHALL be 0 in that state.

Reset
REQ-024 reset_i low -> state IDLE, counter 0, sel 0, last-served pointer 1, all outputs 0, asynchronously.
REQ-025 Reset in any state, including mid-EXEC, aborts the operation with no done_o pulse; operation resumes only from a fresh request.

Configuration
REQ-026 CALC_SCHED_RR_EN defined: round-robin arbitration; on simultaneous requests, grant the requester not last served; pointer updates in LOAD.
REQ-027 CALC_SCHED_RR_EN undefined: fixed priority, requester 0 always wins; pointer logic absent.

Structure
REQ-028 Shared package calc_pkg SHALL hold the op encoding (ADD=00, SUB=01, MUL=10, DIV=11) and the state enumeration.
REQ-029 The arbiter SHALL be a separate sub-module calc_arb (req in, one-hot grant out, pointer internal); the FSM and counter stay in calc_sched.

Verification
REQ-030 Reset low mid-EXEC of a MUL -> next edge state IDLE, all outputs 0, no done_o; busy_o=0.
REQ-031 req_i=01, fct_i[1:0]=ADD at T -> gnt_o=01 at T+1, step_o at T+2, res_we_o at T+3, done_o=01 at T+4, rem_we_o never set.
REQ-032 WIDTH=8, req_i=10, fct_i[3:2]=MUL -> step_o high 8 consecutive cycles, done_o=10 at T+11, sel_o=1 throughout.
REQ-033 DIV from requester 0 -> res_we_o and rem_we_o both high in the same STORE cycle.
REQ-034 RR_EN, req_i=11 held -> grants 01, 10, 01 in successive operations; without RR_EN -> 01, 01, 01.
REQ-035 req_i toggled during EXEC -> no extra gnt_o, busy_o stays 1 until DONE completes.
